// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the serial pattern-scan controller.
package pattern_scan_pkg;

    localparam int MAXLEN_DEF = 8;
    localparam int MASK_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Low-len-bits mask; callers truncate to their pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// History shift register, fill counter and masked pattern compare.
module pattern_match_core
    import pattern_scan_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LENW   = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              R,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              in,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    input  logic              overlap,
    output logic              hit
);

    logic [MAXLEN-1:0] hist;
    logic [MAXLEN-1:0] hist_nxt;
    logic [MAXLEN-1:0] mask;
    logic [LENW-1:0]   fill;
    logic [LENW-1:0]   fill_inc;

    assign hist_nxt = {hist[MAXLEN-2:0], in};
    assign mask     = MAXLEN'(len_mask(32'(len)));
    assign fill_inc = (fill == LENW'(MAXLEN)) ? fill : fill + 1'b1;

    // Compare against the history including the bit arriving this cycle.
    assign hit = shift_en && (fill_inc >= len)
                 && (((hist_nxt ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (R || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
            fill <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Configure/start/scan/done controller around the pattern match core.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int LENW   = $clog2(MAXLEN + 1),
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_window,
    input  logic              start,
    input  logic              in,
    input  logic              in_valid,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [CNTW-1:0]   match_count
);

    state_t            state;
    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   win_q;
    logic [CNTW-1:0]   remaining;

    logic [LENW-1:0]   eff_len;
    logic [CNTW-1:0]   eff_win;
    logic              len_ok;
    logic              shift_en;
    logic              clr;
    logic              hit;

    // A config offered alongside start is taken first.
    assign eff_len   = cfg_valid ? cfg_len : len_q;
    assign eff_win   = cfg_valid ? cfg_window : win_q;
    assign len_ok    = (eff_len != '0) && (eff_len <= LENW'(MAXLEN));
    assign shift_en  = (state == SCAN) && in_valid && (remaining != '0);
    assign clr       = (state != SCAN);
    assign cfg_ready = (state == IDLE) && !R;

    pattern_match_core #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_core (
        .clk      (clk),
        .R        (R),
        .shift_en (shift_en),
        .clr      (clr),
        .in       (in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            win_q       <= '0;
            remaining   <= '0;
            out         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
        end else begin
            out  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        pat_q   <= cfg_pattern;
                        len_q   <= cfg_len;
                        ovl_q   <= cfg_overlap;
                        win_q   <= cfg_window;
                        cfg_err <= 1'b0;
                    end
                    if (start) begin
                        if (len_ok) begin
                            match_count <= '0;
                            remaining   <= eff_win;
                            busy        <= 1'b1;
                            state       <= SCAN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (remaining == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (in_valid) begin
                        remaining <= remaining - 1'b1;
                        if (hit) begin
                            out <= 1'b1;
                            if (!(&match_count))
                                match_count <= match_count + 1'b1;
                        end
                        if (remaining == CNTW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_window = '0;
    logic       start = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       out, busy, done, cfg_err;
    logic [7:0] match_count;

    logic       s_cfg_valid = 1'b0;
    logic       s_cfg_ready;
    logic [7:0] s_cfg_pattern = '0;
    logic [3:0] s_cfg_len = '0;
    logic       s_cfg_overlap = 1'b0;
    logic [1:0] s_cfg_window = '0;
    logic       s_start = 1'b0;
    logic       s_in = 1'b0;
    logic       s_in_valid = 1'b0;
    logic       s_out, s_busy, s_done, s_cfg_err;
    logic [1:0] s_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl dut (
        .clk(clk), .R(R), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .start(start), .in(in), .in_valid(in_valid), .out(out),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .match_count(match_count)
    );

    pattern_scan_ctrl #(.MAXLEN(8), .CNTW(2)) dut2 (
        .clk(clk), .R(R), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_pattern(s_cfg_pattern), .cfg_len(s_cfg_len),
        .cfg_overlap(s_cfg_overlap), .cfg_window(s_cfg_window),
        .start(s_start), .in(s_in), .in_valid(s_in_valid), .out(s_out),
        .busy(s_busy), .done(s_done), .cfg_err(s_cfg_err),
        .match_count(s_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_start(input logic [7:0] p, input logic [3:0] l,
                             input logic o, input logic [7:0] w);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l;
        cfg_overlap = o; cfg_window = w; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        R = 1'b1;
        tick(); tick();
        R = 1'b0;
        #1;
        n_total++;
        if ({out, busy, done, cfg_err} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {out, busy, done, cfg_err});
        else n_pass++;
        n_total++;
        if (match_count !== 8'd0) $display("FAIL rst_count got %0d want 0", match_count);
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", cfg_ready);
        else n_pass++;
        n_total++;
        if (s_count !== 2'd0 || s_cfg_ready !== 1'b1) $display("FAIL rst_dut2 got %0d/%b want 0/1", s_count, s_cfg_ready);
        else n_pass++;
    endtask

    task automatic test_stream(input string nm, input logic o,
                               input logic [4:0] bits, input logic [4:0] exp_out,
                               input logic [7:0] exp_cnt);
        logic e;
        cfg_start(8'b101, 4'd3, o, 8'd5);
        n_total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL %s_busy got %b/%b want 1/0", nm, busy, cfg_ready);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            in = bits[4-k]; in_valid = 1'b1;
            tick();
            e = exp_out[4-k];
            n_total++;
            if (out !== e) $display("FAIL %s_out[%0d] got %b want %b", nm, k, out, e);
            else n_pass++;
        end
        in_valid = 1'b0;
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_done got %b/%b want 1/0", nm, done, busy);
        else n_pass++;
        n_total++;
        if (match_count !== exp_cnt) $display("FAIL %s_count got %0d want %0d", nm, match_count, exp_cnt);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL %s_idle got %b/%b want 0/1", nm, done, cfg_ready);
        else n_pass++;
    endtask

    task automatic test_gap;
        logic [5:0] bits;
        logic [5:0] exp_out;
        bits = 6'b101101;
        exp_out = 6'b001001;
        cfg_start(8'b101, 4'd3, 1'b1, 8'd6);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                in_valid = 1'b0; in = 1'b1;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    n_total++;
                    if (out !== 1'b0 || busy !== 1'b1) $display("FAIL gap_hold[%0d] got %b/%b want 0/1", g, out, busy);
                    else n_pass++;
                end
            end
            in = bits[5-k]; in_valid = 1'b1;
            tick();
            n_total++;
            if (out !== exp_out[5-k]) $display("FAIL gap_out[%0d] got %b want %b", k, out, exp_out[5-k]);
            else n_pass++;
            if (k < 5) begin
                n_total++;
                if (busy !== 1'b1) $display("FAIL gap_busy[%0d] got %b want 1", k, busy);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (match_count !== 8'd2 || done !== 1'b1) $display("FAIL gap_end got %0d/%b want 2/1", match_count, done);
        else n_pass++;
        tick();
    endtask

    task automatic test_cfg_err;
        cfg_start(8'b101, 4'd0, 1'b0, 8'd4);
        n_total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) $display("FAIL err_len0 got %b/%b want 1/0", cfg_err, busy);
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL err_ready got %b want 1", cfg_ready);
        else n_pass++;
        n_total++;
        if (match_count !== 8'd2) $display("FAIL err_count_hold got %0d want 2", match_count);
        else n_pass++;
        cfg_start(8'b101, 4'd9, 1'b0, 8'd4);
        tick();
        n_total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) $display("FAIL err_len9 got %b/%b want 1/0", cfg_err, busy);
        else n_pass++;
        cfg_valid = 1'b1; cfg_len = 4'd3;
        tick();
        cfg_valid = 1'b0;
        n_total++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) $display("FAIL err_clear got %b/%b want 0/0", cfg_err, busy);
        else n_pass++;
    endtask

    task automatic test_window0;
        cfg_start(8'b1, 4'd1, 1'b1, 8'd0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL w0_busy got %b want 1", busy);
        else n_pass++;
        in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if ({busy, done, out} !== 3'b010) $display("FAIL w0_done got %b want 010", {busy, done, out});
        else n_pass++;
        n_total++;
        if (match_count !== 8'd0) $display("FAIL w0_count got %0d want 0", match_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back;
        s_cfg_valid = 1'b1; s_cfg_pattern = 8'b1; s_cfg_len = 4'd1;
        s_cfg_overlap = 1'b1; s_cfg_window = 2'd3; s_start = 1'b1;
        tick();
        s_cfg_valid = 1'b0; s_start = 1'b0;
        s_in = 1'b1; s_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (s_out !== 1'b1 || s_count !== 2'(k + 1)) $display("FAIL b2b_pulse[%0d] got %b/%0d want 1/%0d", k, s_out, s_count, k + 1);
            else n_pass++;
        end
        s_in_valid = 1'b0;
        n_total++;
        if (s_done !== 1'b1) $display("FAIL b2b_done got %b want 1", s_done);
        else n_pass++;
        tick();
        n_total++;
        if (s_out !== 1'b0 || s_count !== 2'd3) $display("FAIL b2b_hold got %b/%0d want 0/3", s_out, s_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan;
        cfg_start(8'b1, 4'd1, 1'b0, 8'd5);
        in = 1'b1; in_valid = 1'b1;
        tick(); tick();
        n_total++;
        if (match_count !== 8'd2) $display("FAIL mid_pre got %0d want 2", match_count);
        else n_pass++;
        R = 1'b1;
        tick();
        R = 1'b0; in_valid = 1'b0;
        #1;
        n_total++;
        if ({busy, out, done} !== 3'b000 || match_count !== 8'd0) $display("FAIL mid_rst got %b/%0d want 000/0", {busy, out, done}, match_count);
        else n_pass++;
        n_total++;
        if (cfg_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", cfg_ready);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_nodone got %b/%b want 0/0", done, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream("ovl", 1'b1, 5'b10101, 5'b00101, 8'd2);
        test_stream("novl", 1'b0, 5'b10101, 5'b00100, 8'd1);
        test_gap();
        test_cfg_err();
        test_window0();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Programmable serial pattern-scan controller. It accepts a pattern configuration of up to MAXLEN bits, then scans a window of serial input bits for that pattern in overlapping or non-overlapping mode. It emits a registered Mealy-style match pulse per hit and reports a saturating hit count on completion. It generalises the fixed-pattern sequence detectors and sequences them: configure, start, scan, done.

## Interface
- MAXLEN, 8: maximum pattern length in bits (≥2)
- LENW, $clog2(MAXLEN+1): width of the length field
- CNTW, 8: width of the window and match counters
- clk  input  1  clock, rising edge
- R  input  1  reset, synchronous, active-high
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  configuration accepted; high only in IDLE
- cfg_pattern  input  MAXLEN  pattern; bit 0 is the last bit of the sequence
- cfg_len  input  LENW  pattern length, legal range 1..MAXLEN
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_window  input  CNTW  number of input bits to scan
- start  input  1  begin scan with the stored configuration
- in  input  1  serial data bit
- in_valid  input  1  `in` is valid this cycle
- out  output  1  match pulse (one cycle per hit)
- busy  output  1  high in SCAN
- done  output  1  one-cycle pulse at end of scan
- cfg_err  output  1  sticky; set when start is issued with an illegal length
- match_count  output  CNTW  hits in the last or current scan; saturates

## Operation
- Reset values: out=0, busy=0, done=0, cfg_err=0, match_count=0, cfg_ready=1, state=IDLE. Stored config clears to pattern 0, len 0, overlap 0, window 0.
- States are IDLE, SCAN and DONE.
- IDLE:
  - cfg_valid && cfg_ready latches pattern, len, overlap and window, and clears cfg_err.
  - If start arrives with stored len in 1..MAXLEN: clear match_count, history and fill counter; load remaining=window; go to SCAN.
  - If start arrives with len 0 or len>MAXLEN: set cfg_err and stay in IDLE.
  - If start and cfg_valid arrive in the same cycle, the config is taken first. Start uses the newly latched values.
- SCAN:
  - Each cycle with in_valid, shift `in` into history (hist = {hist, in}), increment fill (saturate at MAXLEN), and decrement remaining.
  - A hit occurs when fill ≥ len and the low `len` bits of the updated history equal the low `len` bits of the pattern.
  - On a hit: out=1 next cycle, and match_count increments, saturating at 2^CNTW−1.
  - Non-overlap mode: a hit resets fill to 0, so the next hit needs `len` fresh bits.
  - Overlap mode: fill is kept.
  - When remaining reaches 0 after a consumed bit, go to DONE.
  - Window 0: SCAN exits on its first cycle without consuming any bits.
  - in_valid=0 holds everything; out=0 that cycle.
  - start and cfg_valid are ignored in SCAN.
- DONE: done=1 for one cycle, then go to IDLE. match_count holds until the next start.
- R at any time, including mid-scan, returns everything to reset values on the next edge.

## Timing
- out is registered. It is high in the cycle after the edge that sampled the completing bit, for one cycle per hit. Back-to-back hits give consecutive out pulses.
- Latency from start edge to first bit sampled is 1 cycle: the bit is sampled on the first SCAN cycle edge.
- The final out pulse and done coincide when the last window bit completes a match. match_count already includes that hit in that cycle.
- busy is high exactly in SCAN cycles.
- cfg_ready = (state==IDLE) && !R.

## Structure
- Package pattern_scan_pkg holds:
  - the state enum (IDLE, SCAN, DONE)
  - MAXLEN default
  - a helper function `len_mask(len)` giving the low-`len`-bits mask.
- Sub-module pattern_match_core holds the history shift register, fill counter and masked compare. Its ports are shift_en, clr, in, pattern, len, overlap, and hit (combinational).
- The top level owns the FSM, the window counter, the output registers and the config registers.

## Test plan
- Overlap, pattern 3'b101, len 3, window 5, stream 1,0,1,0,1 → out pulses after bits 3 and 5; match_count=2; done one cycle after the 5th bit's edge.
- Same stream with non-overlap → single pulse after bit 3; match_count=1.
- Stream 1,0,1,1,0,1 with in_valid deasserted for 2 cycles between bits 2 and 3 → hits after bits 3 and 6 (count 2); no pulse during the gap; busy high throughout.
- start with len=0, then len=9 (MAXLEN=8) → cfg_err=1, no SCAN; a new config clears cfg_err.
- CNTW=2, pattern 1'b1, len 1, window 3, stream all ones → three pulses; match_count saturates at 3.
- Assert R in cycle 3 of the scan → next cycle: busy=0, out=0, match_count=0, cfg_ready=1, no done pulse.
